// File: rtl/alu_src_a_stage.sv
// Registered operand-A selector for the multicycle ALU: source / zero / illegal decode into a
// one-entry valid/ready output register. Optional forwarding path under `ALU_SRC_A_BYPASS_EN`.
module alu_src_a_stage #(
    parameter int DATA_W  = 32,
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [SEL_W-1:0]          sel,
    input  logic [NUM_SRC*DATA_W-1:0] src_bus,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      illegal_sel,
    output logic [7:0]                err_count,
    input  logic                      clear_err
`ifdef ALU_SRC_A_BYPASS_EN
   ,input  logic                      fwd_en,
    input  logic [DATA_W-1:0]         fwd_data
`endif
);

    // The select code one past the last source is the constant-zero code.
    localparam logic [SEL_W-1:0] ZERO_CODE = SEL_W'(NUM_SRC);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_data;
    logic                r_illegal;
    logic [7:0]          r_err_cnt;

    logic                w_accept;
    logic                w_src_legal;
    logic                w_illegal;
    logic [DATA_W-1:0]   w_src_word;
    logic [DATA_W-1:0]   w_cap_data;
    logic [7:0]          w_err_inc;

    assign in_ready    = (r_state == S_EMPTY) || out_ready;
    assign w_accept    = in_valid && in_ready;
    assign w_src_legal = (sel < ZERO_CODE);
    assign w_illegal   = (sel > ZERO_CODE);

    always_comb begin
        w_src_word = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i))
                w_src_word = src_bus[i*DATA_W +: DATA_W];
        end
    end

    // Zero and illegal codes both capture 0; forwarding only overrides a real source.
    always_comb begin
        w_cap_data = '0;
        if (w_src_legal) begin
`ifdef ALU_SRC_A_BYPASS_EN
            w_cap_data = fwd_en ? fwd_data : w_src_word;
`else
            w_cap_data = w_src_word;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
            S_FULL: begin
                if (w_accept)       w_state_nxt = S_FULL;
                else if (out_ready) w_state_nxt = S_EMPTY;
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_EMPTY;
        else       r_state <= w_state_nxt;
    end

    // out_data is intentionally not cleared on drain; it only changes on accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         r_data <= '0;
        else if (w_accept) r_data <= w_cap_data;
    end

    assign w_err_inc = (r_err_cnt == 8'hFF) ? 8'hFF : r_err_cnt + 8'd1;

    // A same-cycle illegal accept wins over clear_err, restarting the count at 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_illegal <= 1'b0;
            r_err_cnt <= 8'd0;
        end else if (w_accept && w_illegal) begin
            r_illegal <= 1'b1;
            r_err_cnt <= clear_err ? 8'd1 : w_err_inc;
        end else if (clear_err) begin
            r_illegal <= 1'b0;
            r_err_cnt <= 8'd0;
        end
    end

    assign out_valid   = (r_state == S_FULL);
    assign out_data    = r_data;
    assign illegal_sel = r_illegal;
    assign err_count   = r_err_cnt;

endmodule

// File: tb/tb_alu_src_a_stage.sv
// Self-checking bench for alu_src_a_stage: reference model plus a queue of expected captures.
module tb_alu_src_a_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  sel;
    logic [63:0] src_bus;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        illegal_sel;
    logic [7:0]  err_count;
    logic        clear_err;
    logic        fwd_en;
    logic [31:0] fwd_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] sb_q[$];
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_ill;
    int          m_err;

    always #5 clk = ~clk;

    alu_src_a_stage #(.DATA_W(32), .NUM_SRC(2), .SEL_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .sel        (sel),
        .src_bus    (src_bus),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .illegal_sel(illegal_sel),
        .err_count  (err_count),
        .clear_err  (clear_err)
`ifdef ALU_SRC_A_BYPASS_EN
       ,.fwd_en     (fwd_en),
        .fwd_data   (fwd_data)
`endif
    );

    function automatic logic [31:0] exp_word(input logic [1:0] s, input logic [63:0] bus,
                                             input logic fe, input logic [31:0] fd);
        if (s < 2'd2) begin
`ifdef ALU_SRC_A_BYPASS_EN
            if (fe) return fd;
`endif
            return bus[int'(s)*32 +: 32];
        end
        return 32'h0;
    endfunction

    function automatic void model_reset();
        m_valid = 1'b0;
        m_data  = 32'h0;
        m_ill   = 1'b0;
        m_err   = 0;
        sb_q.delete();
    endfunction

    // One clock of stimulus: checks in_ready before the edge, everything else #1 after it.
    task automatic step(input logic [1:0] s, input logic iv, input logic ordy, input logic clr);
        logic        acc;
        logic [31:0] exp_pop;
        sel = s; in_valid = iv; out_ready = ordy; clear_err = clr;
        #1;
        checks++;
        if (in_ready !== (!m_valid || ordy)) begin
            errors++;
            $display("FAIL in_ready: got %b expected %b", in_ready, !m_valid || ordy);
        end
        acc = iv && (!m_valid || ordy);
        if (acc) begin
            sb_q.push_back(exp_word(s, src_bus, fwd_en, fwd_data));
            m_valid = 1'b1;
            m_data  = exp_word(s, src_bus, fwd_en, fwd_data);
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        if (acc && s > 2'd2) begin
            m_ill = 1'b1;
            m_err = clr ? 1 : ((m_err == 255) ? 255 : m_err + 1);
        end else if (clr) begin
            m_ill = 1'b0;
            m_err = 0;
        end
        @(posedge clk);
        #1;
        if (acc) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: queue empty on accept");
            end else begin
                exp_pop = sb_q.pop_front();
                if (out_data !== exp_pop) begin
                    errors++;
                    $display("FAIL capture: out_data got %h expected %h", out_data, exp_pop);
                end
            end
        end
        checks++;
        if (out_valid !== m_valid || out_data !== m_data) begin
            errors++;
            $display("FAIL state: valid/data got %b/%h expected %b/%h",
                     out_valid, out_data, m_valid, m_data);
        end
        checks++;
        if (illegal_sel !== m_ill || err_count !== 8'(m_err)) begin
            errors++;
            $display("FAIL errflags: ill/cnt got %b/%0d expected %b/%0d",
                     illegal_sel, err_count, m_ill, m_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; sel = 2'd0; src_bus = '0; in_valid = 1'b0; out_ready = 1'b0;
        clear_err = 1'b0; fwd_en = 1'b0; fwd_data = '0;
        model_reset();
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || illegal_sel !== 1'b0 ||
            err_count !== 8'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: v=%b d=%h ill=%b cnt=%0d rdy=%b expected 0/0/0/0/1",
                     out_valid, out_data, illegal_sel, err_count, in_ready);
        end
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        src_bus = {32'h0000_BEEF, 32'h0000_0040};
        step(2'd0, 1'b1, 1'b1, 1'b0);
        step(2'd1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_zero_illegal();
        step(2'd2, 1'b1, 1'b1, 1'b0);
        step(2'd3, 1'b1, 1'b1, 1'b0);
        step(2'd0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_stall();
        src_bus = {32'h1111_2222, 32'h3333_4444};
        step(2'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            src_bus = {$urandom, $urandom};
            step(2'($urandom_range(0, 3)), 1'b1, 1'b0, 1'b0);
        end
        src_bus = {32'hA5A5_0001, 32'h5A5A_0002};
        step(2'd1, 1'b1, 1'b1, 1'b0);
        step(2'd0, 1'b0, 1'b1, 1'b0);
        step(2'd1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            src_bus = {$urandom, $urandom};
            step(2'($urandom_range(0, 2)), 1'b1, 1'b1, 1'b0);
        end
    endtask

    task automatic test_saturate();
        step(2'd0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) step(2'd3, 1'b1, 1'b1, 1'b0);
        step(2'd3, 1'b1, 1'b1, 1'b1);
        step(2'd3, 1'b1, 1'b1, 1'b0);
        step(2'd0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_async_reset();
        src_bus = {32'h0000_1234, 32'h0000_5678};
        step(2'd3, 1'b1, 1'b1, 1'b0);
        step(2'd1, 1'b1, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || err_count !== 8'd0 ||
            illegal_sel !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: v=%b d=%h cnt=%0d ill=%b rdy=%b expected 0/0/0/0/1",
                     out_valid, out_data, err_count, illegal_sel, in_ready);
        end
        model_reset();
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        step(2'd0, 1'b1, 1'b1, 1'b0);
    endtask

`ifdef ALU_SRC_A_BYPASS_EN
    task automatic test_bypass();
        src_bus = {32'h0000_BEEF, 32'h0000_0040};
        fwd_en = 1'b1; fwd_data = 32'h0000_CAFE;
        step(2'd1, 1'b1, 1'b1, 1'b0);
        step(2'd2, 1'b1, 1'b1, 1'b0);
        step(2'd0, 1'b1, 1'b1, 1'b0);
        fwd_en = 1'b0;
        step(2'd0, 1'b1, 1'b1, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_illegal();
        test_stall();
        test_back_to_back();
        test_saturate();
        test_async_reset();
`ifdef ALU_SRC_A_BYPASS_EN
        test_bypass();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_src_a_stage.md
# alu_src_a_stage

Parametrised, registered operand-A selector for the multicycle datapath ALU. It picks one of `NUM_SRC` source words, or a constant zero, and captures the result into a one-entry output register. The register has a valid/ready handshake, so the ALU operand can be held across stalls. Illegal select codes are flagged and counted instead of propagating X. The block sits between the PC / temporary-A register outputs and ALU input A, replacing the purely combinational A-side mux.

## Interface
Parameters:
- `DATA_W`, 32, operand width in bits.
- `NUM_SRC`, 2, number of data sources. Source 0 is conventionally PC, source 1 is temp register A.
- `SEL_W`, 2, select width. Must satisfy 2^SEL_W > NUM_SRC.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `sel`  in  `SEL_W`  source select, sampled on accept.
- `src_bus`  in  `NUM_SRC*DATA_W`  flattened sources; source i occupies bits [i*DATA_W +: DATA_W].
- `in_valid`  in  1  upstream offers a selection this cycle.
- `in_ready`  out  1  stage can accept this cycle.
- `out_data`  out  `DATA_W`  registered operand to the ALU.
- `out_valid`  out  1  `out_data` holds a live operand.
- `out_ready`  in  1  ALU consumes the operand this cycle.
- `illegal_sel`  out  1  sticky flag: an illegal select was accepted.
- `err_count`  out  8  saturating count of illegal selects accepted.
- `clear_err`  in  1  synchronous clear of `illegal_sel` and `err_count`.

## Operation
- Select decode at accept time:
  - `sel` < `NUM_SRC` → the selected source word.
  - `sel` == `NUM_SRC` → constant 0.
  - `sel` > `NUM_SRC` → illegal: capture 0, set `illegal_sel`, increment `err_count`.
- Two states:
  - EMPTY: `out_valid`=0.
  - FULL: `out_valid`=1.
- `in_ready` = !`out_valid` || `out_ready`, purely combinational from state and `out_ready`.
- Accept = `in_valid` && `in_ready`. Accept loads `out_data` and the state goes to FULL.
- FULL && `out_ready` && no accept → EMPTY. `out_data` keeps its last value; it is not cleared.
- FULL && !`out_ready` → hold `out_data` stable, regardless of `sel`/`src_bus` changes.
- `err_count` saturates at 255 and does not wrap. `illegal_sel` stays 1 until clear or reset.
- `clear_err` and an illegal accept in the same cycle: the result is `err_count`=1 and `illegal_sel`=1. The new event survives the clear.
- `clear_err` alone: both error outputs are 0 next cycle.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `illegal_sel`=0, `err_count`=0. `in_ready`=1 while reset is asserted.
- Reset takes effect immediately and asynchronously, mid-transfer included. A held operand is discarded.
- Latency: 1 cycle from accept to `out_valid`/`out_data`.
- Throughput: 1 operand per cycle. FULL with `out_ready`=1 and `in_valid`=1 replaces the operand in the same edge, with no bubble.
- No combinational path from `sel`, `src_bus` or `in_valid` to any output. `in_ready` depends only on `out_ready` and state.
- `err_count` and `illegal_sel` update on the same edge that captures the illegal operand.

## Configuration
- Macro `ALU_SRC_A_BYPASS_EN`.
- Defined:
  - Adds ports `fwd_en` (in, 1) and `fwd_data` (in, `DATA_W`).
  - On an accept with `fwd_en`=1 and a legal source select (`sel` < `NUM_SRC`), `fwd_data` is captured in place of the source word.
  - Zero selects and illegal selects ignore forwarding.
- Undefined: the ports do not exist and the behaviour is exactly as above.

## Test plan
- Reset, then `sel`=0, `src_bus`={B:0x0000_BEEF, PC:0x0000_0040}, `in_valid`=1, `out_ready`=1 → next cycle `out_data`=0x40, `out_valid`=1; `sel`=1 the following cycle → `out_data`=0xBEEF.
- `sel`=2 (zero code, default parameters) → `out_data`=0, `illegal_sel`=0; `sel`=3 → `out_data`=0, `illegal_sel`=1, `err_count`=1.
- Fill the stage, then `out_ready`=0 for 5 cycles while `src_bus` and `sel` toggle → `out_data` stable, `in_ready`=0; raise `out_ready` with `in_valid`=1 → new operand on the next edge with no empty cycle.
- 300 consecutive illegal accepts → `err_count`=255. Then `clear_err` together with one more illegal accept → `err_count`=1, `illegal_sel`=1.
- Assert `reset` asynchronously between edges while FULL → `out_valid`=0, `out_data`=0 and `err_count`=0 before the next edge.
- With `ALU_SRC_A_BYPASS_EN`: `sel`=1, `fwd_en`=1, `fwd_data`=0xCAFE → `out_data`=0xCAFE; `sel`=2 with `fwd_en`=1 → `out_data`=0.
